// File: rtl/approx_add_arbiter.sv
// approx_add_arbiter: round-robin arbiter feeding one shared exact/lower-part-approximate adder into a one-entry result register.
// Optional APPROX_ERR_STAT_EN counts approximate results that differ from the exact sum.
module approx_add_arbiter #(
  parameter int N   = 16,
  parameter int LPL = 6,
  parameter int UPL = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  input  logic         req0_exact,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  input  logic         req1_exact,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [N:0]   res_data,
  output logic         res_id,
  output logic         res_exact,
  output logic [15:0]  err_count
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t state;
  logic ptr, g1, can_accept, xfer, sel_exact, c;
  logic [N-1:0] sel_a, sel_b;
  logic [N:0] exact_sum, approx_sum, sum;
  logic [UPL:0] upper;
  logic [LPL-1:0] r;
  assign res_valid = state == FULL;
  // ptr=1 means requester 1 wins a tie; ready is suppressed during reset
  always_comb begin
    can_accept = (state == EMPTY) | res_ready;
    g1 = req1_valid & (~req0_valid | ptr);
    req0_ready = ~rst & can_accept & req0_valid & ~g1;
    req1_ready = ~rst & can_accept & g1;
    xfer = req0_ready | req1_ready;
    sel_a = g1 ? req1_a : req0_a;
    sel_b = g1 ? req1_b : req0_b;
    sel_exact = g1 ? req1_exact : req0_exact;
    exact_sum = {1'b0, sel_a} + {1'b0, sel_b};
    c = sel_a[LPL-1] & sel_b[LPL-1];
    r = '1;
    r[LPL-1] = (c ? 1'b0 : sel_a[LPL-1] | sel_b[LPL-1]) | (sel_a[LPL-2] & sel_b[LPL-2]);
    r[LPL-2] = sel_a[LPL-2] | sel_b[LPL-2];
    upper = {1'b0, sel_a[N-1:LPL]} + {1'b0, sel_b[N-1:LPL]} + {{UPL{1'b0}}, c};
    approx_sum = {upper, r};
    sum = sel_exact ? exact_sum : approx_sum;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      res_data <= '0;
      res_id <= 1'b0;
      res_exact <= 1'b0;
      ptr <= 1'b0;
    end else if (xfer) begin
      state <= FULL;
      res_data <= sum;
      res_id <= g1;
      res_exact <= sel_exact;
      ptr <= ~g1;
    end else if (res_ready) begin
      state <= EMPTY;
    end
  end
`ifdef APPROX_ERR_STAT_EN
  always_ff @(posedge clk) begin
    if (rst) err_count <= '0;
    else if (xfer & ~sel_exact & (approx_sum != exact_sum) & (err_count != 16'hFFFF)) err_count <= err_count + 16'd1;
  end
`else
  assign err_count = '0;
`endif
endmodule
